// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised redirects (trap > mret > branch),
// sequential 2/4-byte stepping, and an epoch tag that advances on every redirect.
module pc_gen #(
   parameter int unsigned XLEN    = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(64'h8000_0000),
   parameter bit          C_EXT   = 1'b1,
   parameter int unsigned EPOCH_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trap_valid,
   input  logic               trap_irq,
   input  logic [5:0]         trap_cause,
   input  logic [XLEN-1:0]    mtvec,
   input  logic               mret_valid,
   input  logic [XLEN-1:0]    mepc,
   input  logic               br_valid,
   input  logic               br_abs,
   input  logic [XLEN-1:0]    br_base,
   input  logic [XLEN-1:0]    br_offset,
   input  logic               stall,
   input  logic               fetch_is_c,
   input  logic               pc_ready,
   output logic [XLEN-1:0]    pc,
   output logic               pc_valid,
   output logic [EPOCH_W-1:0] pc_epoch,
   output logic               flush,
   output logic               target_misaligned
);

   typedef enum logic [1:0] {BOOT, RUN, REFILL} state_e;

   localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

   state_e               state_q;
   logic [XLEN-1:0]      pc_q;
   logic                 valid_q;
   logic [EPOCH_W-1:0]   epoch_q;
   logic                 flush_q;
   logic                 mis_q;

   logic                 redirect_c;
   logic                 accept_c;
   logic [XLEN-1:0]      trap_base_c;
   logic [XLEN-1:0]      trap_tgt_c;
   logic [XLEN-1:0]      br_sum_c;
   logic [XLEN-1:0]      br_raw_c;
   logic [XLEN-1:0]      pc_d;
   logic                 mis_d;
   logic [XLEN-1:0]      step_c;

   // Redirect target selection and alignment check
   always_comb begin
      trap_base_c = mtvec & ~XLEN'(3);
      trap_tgt_c  = trap_base_c;
      if (mtvec[0] && trap_irq)
         trap_tgt_c = trap_base_c + {{(XLEN-8){1'b0}}, trap_cause, 2'b00};
      br_sum_c = br_base + br_offset;
      br_raw_c = br_abs ? (br_sum_c & ~XLEN'(1)) : br_sum_c;
      pc_d  = br_raw_c & ALIGN_MASK;
      mis_d = |(br_raw_c & ~ALIGN_MASK);
      if (trap_valid) begin
         pc_d  = trap_tgt_c;
         mis_d = 1'b0;
      end else if (mret_valid) begin
         pc_d  = mepc & ALIGN_MASK;
         mis_d = 1'b0;
      end
   end

   assign redirect_c = trap_valid | mret_valid | br_valid;
   assign accept_c   = valid_q & pc_ready & ~stall;
   assign step_c     = (C_EXT && fetch_is_c) ? XLEN'(2) : XLEN'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         epoch_q <= '0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         flush_q <= redirect_c;
         mis_q   <= redirect_c & mis_d;
         valid_q <= ~redirect_c;
         if (redirect_c) begin
            pc_q    <= pc_d;
            epoch_q <= epoch_q + EPOCH_W'(1);
            state_q <= REFILL;
         end else begin
            case (state_q)
               BOOT, REFILL: state_q <= RUN;
               RUN: if (accept_c) pc_q <= pc_q + step_c;
               default: state_q <= BOOT;
            endcase
         end
      end
   end

   assign pc                = pc_q;
   assign pc_valid          = valid_q;
   assign pc_epoch          = epoch_q;
   assign flush             = flush_q;
   assign target_misaligned = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; a second instance with C_EXT=0 shares all inputs.
module tb_pc_gen;
   localparam int unsigned XLEN = 64;
   localparam logic [63:0] RV   = 64'h8000_0000;

   logic clk = 1'b0;
   logic rst_n, trap_valid, trap_irq, mret_valid, br_valid, br_abs;
   logic stall, fetch_is_c, pc_ready;
   logic [5:0]  trap_cause;
   logic [63:0] mtvec, mepc, br_base, br_offset;

   logic [63:0] pc, pc_nc;
   logic        pc_valid, flush, mis, pc_valid_nc, flush_nc, mis_nc;
   logic [1:0]  epoch, epoch_nc;

   logic [1:0]  exp_ep;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(XLEN), .C_EXT(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .trap_valid(trap_valid), .trap_irq(trap_irq),
      .trap_cause(trap_cause), .mtvec(mtvec), .mret_valid(mret_valid), .mepc(mepc),
      .br_valid(br_valid), .br_abs(br_abs), .br_base(br_base), .br_offset(br_offset),
      .stall(stall), .fetch_is_c(fetch_is_c), .pc_ready(pc_ready),
      .pc(pc), .pc_valid(pc_valid), .pc_epoch(epoch), .flush(flush),
      .target_misaligned(mis));

   pc_gen #(.XLEN(XLEN), .C_EXT(1'b0)) u_nc (
      .clk(clk), .rst_n(rst_n), .trap_valid(trap_valid), .trap_irq(trap_irq),
      .trap_cause(trap_cause), .mtvec(mtvec), .mret_valid(mret_valid), .mepc(mepc),
      .br_valid(br_valid), .br_abs(br_abs), .br_base(br_base), .br_offset(br_offset),
      .stall(stall), .fetch_is_c(fetch_is_c), .pc_ready(pc_ready),
      .pc(pc_nc), .pc_valid(pc_valid_nc), .pc_epoch(epoch_nc), .flush(flush_nc),
      .target_misaligned(mis_nc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      trap_valid = 0; mret_valid = 0; br_valid = 0; br_abs = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; clr(); trap_irq = 0; trap_cause = '0; mtvec = '0; mepc = '0;
      br_base = '0; br_offset = '0; stall = 0; fetch_is_c = 0; pc_ready = 1;
      exp_ep = 0;
      #12;
      checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RV); end
      checks++; if ({pc_valid, flush, mis, epoch} !== 5'b0) begin errors++;
         $display("FAIL reset_flags got v=%b f=%b m=%b e=%0d exp all 0", pc_valid, flush, mis, epoch); end
      @(negedge clk); rst_n = 1;
      tick();
      checks++; if (pc_valid !== 1'b1 || pc !== RV) begin errors++;
         $display("FAIL boot_exit got v=%b pc=%h exp v=1 pc=%h", pc_valid, pc, RV); end
      tick();
      checks++; if (pc !== 64'h8000_0004) begin errors++; $display("FAIL seq1 got %h exp 80000004", pc); end
      tick();
      checks++; if (pc !== 64'h8000_0008) begin errors++; $display("FAIL seq2 got %h exp 80000008", pc); end
   endtask

   task automatic test_stall_ready();
      stall = 1; tick(); tick();
      checks++; if (pc !== 64'h8000_0008) begin errors++; $display("FAIL stall_hold got %h exp 80000008", pc); end
      stall = 0; pc_ready = 0; tick();
      checks++; if (pc !== 64'h8000_0008) begin errors++; $display("FAIL ready_hold got %h exp 80000008", pc); end
      pc_ready = 1; fetch_is_c = 1; tick();
      checks++; if (pc !== 64'h8000_000A) begin errors++; $display("FAIL step_c got %h exp 8000000a", pc); end
      fetch_is_c = 0; tick();
      checks++; if (pc !== 64'h8000_000E) begin errors++; $display("FAIL step_4 got %h exp 8000000e", pc); end
   endtask

   task automatic test_branch();
      br_valid = 1; br_base = 64'h8000_0010; br_offset = -64'sd16; tick(); exp_ep++;
      checks++; if (pc !== RV || flush !== 1'b1 || pc_valid !== 1'b0 || epoch !== exp_ep || mis !== 1'b0) begin
         errors++; $display("FAIL br_rel got pc=%h f=%b v=%b e=%0d m=%b exp pc=%h f=1 v=0 e=%0d m=0",
                            pc, flush, pc_valid, epoch, mis, RV, exp_ep); end
      clr(); tick();
      checks++; if (pc_valid !== 1'b1 || flush !== 1'b0 || pc !== RV) begin errors++;
         $display("FAIL br_bubble got v=%b f=%b pc=%h exp v=1 f=0 pc=%h", pc_valid, flush, pc, RV); end
      br_valid = 1; br_abs = 1; br_base = 64'h8000_0020; br_offset = 64'd1; tick(); exp_ep++;
      checks++; if (pc !== 64'h8000_0020 || mis !== 1'b0 || epoch !== exp_ep) begin errors++;
         $display("FAIL br_jalr got pc=%h m=%b e=%0d exp 80000020 m=0 e=%0d", pc, mis, epoch, exp_ep); end
      br_abs = 0; br_offset = 64'd2; tick(); exp_ep++;
      checks++; if (pc_nc !== 64'h8000_0020 || mis_nc !== 1'b1) begin errors++;
         $display("FAIL nc_misalign got pc=%h m=%b exp 80000020 m=1", pc_nc, mis_nc); end
      checks++; if (pc !== 64'h8000_0022 || mis !== 1'b0) begin errors++;
         $display("FAIL c_half got pc=%h m=%b exp 80000022 m=0", pc, mis); end
      br_offset = 64'd1; tick(); exp_ep++;
      checks++; if (pc !== 64'h8000_0020 || mis !== 1'b1) begin errors++;
         $display("FAIL c_misalign got pc=%h m=%b exp 80000020 m=1", pc, mis); end
      clr(); tick();
      checks++; if (mis !== 1'b0 || flush !== 1'b0 || pc_valid !== 1'b1) begin errors++;
         $display("FAIL pulse_len got m=%b f=%b v=%b exp m=0 f=0 v=1", mis, flush, pc_valid); end
   endtask

   task automatic test_priority();
      trap_valid = 1; mret_valid = 1; br_valid = 1; trap_irq = 1; trap_cause = 6'd7;
      mtvec = 64'h8000_1001; mepc = 64'h8000_0400; br_base = 64'h8000_0001; br_offset = '0;
      tick(); exp_ep++;
      checks++; if (pc !== 64'h8000_101C || mis !== 1'b0 || epoch !== exp_ep) begin errors++;
         $display("FAIL trap_vec got pc=%h m=%b e=%0d exp 8000101c m=0 e=%0d", pc, mis, epoch, exp_ep); end
      trap_irq = 0; tick(); exp_ep++;
      checks++; if (pc !== 64'h8000_1000) begin errors++; $display("FAIL trap_exc got %h exp 80001000", pc); end
      trap_valid = 0; mepc = 64'h8000_0203; tick(); exp_ep++;
      checks++; if (pc !== 64'h8000_0202 || pc_nc !== 64'h8000_0200 || mis !== 1'b0 || mis_nc !== 1'b0) begin
         errors++; $display("FAIL mret got pc=%h nc=%h m=%b/%b exp 80000202 80000200 m=0/0",
                            pc, pc_nc, mis, mis_nc); end
      clr(); tick();
   endtask

   task automatic test_back_to_back();
      br_valid = 1; br_base = 64'h8000_0100; br_offset = '0; tick(); exp_ep++;
      checks++; if (pc_valid !== 1'b0 || epoch !== exp_ep) begin errors++;
         $display("FAIL b2b_first got v=%b e=%0d exp v=0 e=%0d", pc_valid, epoch, exp_ep); end
      br_base = 64'h8000_0200; tick(); exp_ep++;
      checks++; if (pc_valid !== 1'b0 || flush !== 1'b1 || epoch !== exp_ep || pc !== 64'h8000_0200) begin
         errors++; $display("FAIL b2b_second got v=%b f=%b e=%0d pc=%h exp v=0 f=1 e=%0d pc=80000200",
                            pc_valid, flush, epoch, pc, exp_ep); end
      clr(); tick();
      checks++; if (pc_valid !== 1'b1 || flush !== 1'b0 || pc !== 64'h8000_0200) begin errors++;
         $display("FAIL b2b_resume got v=%b f=%b pc=%h exp v=1 f=0 pc=80000200", pc_valid, flush, pc); end
   endtask

   task automatic test_wrap();
      br_valid = 1; br_base = 64'hFFFF_FFFF_FFFF_FFFC; br_offset = '0; tick(); exp_ep++;
      clr(); tick();
      tick();
      checks++; if (pc !== 64'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", pc); end
      for (int i = 0; i < 4; i++) begin
         br_valid = 1; br_base = 64'h8000_0000 + 64'(i * 16); tick(); exp_ep++;
         checks++; if (epoch !== exp_ep) begin errors++;
            $display("FAIL epoch_wrap%0d got %0d exp %0d", i, epoch, exp_ep); end
      end
      clr(); tick();
   endtask

   task automatic test_reset_mid();
      br_valid = 1; br_base = 64'h8000_0500; tick(); clr();
      #2 rst_n = 0;
      #1;
      checks++; if (pc !== RV || epoch !== 2'd0 || pc_valid !== 1'b0 || flush !== 1'b0) begin errors++;
         $display("FAIL reset_mid got pc=%h e=%0d v=%b f=%b exp %h 0 0 0", pc, epoch, pc_valid, flush, RV); end
      @(negedge clk); rst_n = 1; tick();
      checks++; if (pc_valid !== 1'b1 || pc !== RV || epoch !== 2'd0) begin errors++;
         $display("FAIL reset_mid_rel got v=%b pc=%h e=%0d exp 1 %h 0", pc_valid, pc, epoch, RV); end
   endtask

   initial begin
      test_reset();
      test_stall_ready();
      test_branch();
      test_priority();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator at the head of the fetch stage. It replaces the fixed 64-bit PC register and supplies fetch with a PC over a valid/ready handshake. Redirects are prioritised: trap, then mret, then branch. Traps support direct and vectored mtvec modes, sequential stepping supports compressed (2-byte) instructions, and a redirect epoch tag lets downstream stages discard stale fetches.

## Interface
- XLEN, 64, PC and target width (32 or 64)
- RESET_VECTOR, 'h8000_0000, PC value loaded on reset (XLEN bits)
- C_EXT, 1, 1 = 2-byte alignment and 2-byte steps allowed; 0 = 4-byte only
- EPOCH_W, 2, width of the redirect epoch counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- trap_valid  in  1  take trap this cycle
- trap_irq  in  1  trap is an interrupt (selects vectored offset)
- trap_cause  in  6  cause code used in vectored mode
- mtvec  in  XLEN  trap vector CSR; bit 0 = mode (0 direct, 1 vectored)
- mret_valid  in  1  return from trap
- mepc  in  XLEN  return target
- br_valid  in  1  taken branch/jump redirect
- br_abs  in  1  0: target = br_base + br_offset; 1: target = (br_base + br_offset) & ~1 (jalr)
- br_base, br_offset  in  XLEN  target operands
- stall  in  1  hold the PC (pipeline bubble)
- fetch_is_c  in  1  accepted instruction is 2 bytes (ignored when C_EXT=0)
- pc_ready  in  1  fetch accepts pc
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc is valid for fetch
- pc_epoch  out  EPOCH_W  epoch tag travelling with pc
- flush  out  1  one-cycle pulse: a redirect was taken last edge
- target_misaligned  out  1  one-cycle pulse: the redirect target violated alignment

## Operation
- States: BOOT, RUN, REFILL. Reset forces BOOT. BOOT and REFILL always advance to RUN after one cycle unless a new redirect arrives.
- Redirect = trap_valid | mret_valid | br_valid. The redirect is taken in any state, regardless of stall or pc_ready.
- Redirect priority is trap > mret > br. Only the highest-priority target is used.
- Trap target:
  - Direct mode, or vectored mode with trap_irq=0: {mtvec[XLEN-1:2],2'b00}.
  - Vectored mode with trap_irq=1: that base + 4*trap_cause.
- mret target: mepc with bit 0 cleared. When C_EXT=0, bit 1 is also cleared.
- Branch target: computed as above. All additions wrap modulo 2^XLEN.
- Alignment:
  - Branch target with bit 0 set (C_EXT=1), or with bits [1:0] nonzero (C_EXT=0): target_misaligned pulses.
  - The target is still loaded with its low bits cleared to the legal alignment.
  - Trap and mret targets never raise target_misaligned.
- On a redirect: load pc, increment pc_epoch (wraps), pulse flush, enter REFILL.
- A redirect during REFILL reloads pc, increments the epoch again and stays in REFILL.
- In RUN, accept = pc_valid & pc_ready & !stall.
  - On accept, pc += 2 when (C_EXT & fetch_is_c); otherwise pc += 4 (wraps).
  - With no accept, pc holds.
- pc_valid = 1 only in RUN.

## Timing
- Reset (rst_n low, asynchronous):
  - pc = RESET_VECTOR.
  - pc_valid = 0, pc_epoch = 0, flush = 0, target_misaligned = 0.
  - State = BOOT.
- First edge after release: RUN, so pc_valid rises with pc = RESET_VECTOR.
- Redirect latency: redirect sampled at edge t.
  - After t: pc = target, flush = 1, pc_valid = 0, epoch incremented.
  - After t+1: pc_valid = 1, flush = 0.
- Sequential latency: accept sampled at edge t; the new pc is visible after t.
- A redirect and an accept at the same edge: the redirect wins and no increment is applied.
- Asserting reset mid-operation clears everything immediately, including a pending REFILL.
- flush and target_misaligned are registered and last exactly one cycle per redirect.

## Test plan
- Reset release, pc_ready=1, fetch_is_c=0 for 3 cycles:
  - pc_valid low for one cycle.
  - Then pc = 8000_0000, 8000_0004, 8000_0008.
- Stall and ready: stall=1 for 2 cycles holds pc at 8000_0008. pc_ready=0 also holds it. Alternating fetch_is_c=1/0 steps +2, +4.
- Branch with the base at 8000_0010 and the offset at -16:
  - pc = 8000_0000, flush=1, epoch 0->1.
  - One-cycle bubble, then pc_valid.
  - br_abs=1 with target 8000_0021 yields 8000_0020 and no misalign (C_EXT=1).
  - C_EXT=0 with target 8000_0022 yields 8000_0020 and target_misaligned=1.
- Simultaneous trap_valid, mret_valid and br_valid, with mtvec=8000_1001 (vectored), trap_irq=1, cause=7:
  - pc = 8000_101C.
  - Repeat with trap_irq=0: pc = 8000_1000.
- Back-to-back redirects on consecutive cycles: the epoch increments twice, the state stays REFILL, and pc_valid stays low until one quiet cycle has passed.
- Wrap checks:
  - pc = FFFF_FFFF_FFFF_FFFC plus an accept gives 0.
  - Epoch wraps 3->0 after four redirects.
  - rst_n pulsed low during REFILL returns pc to RESET_VECTOR and epoch to 0 immediately.
